aes_round_controller: RTL and testbench
=======================================

# aes_round_controller

Sequencing FSM for the iterative AES encryption datapath. It accepts one plaintext block through a valid/ready handshake and holds the 128-bit state register. Over successive cycles it steps the external round logic through the initial AddRoundKey, rounds 1..Nr-1 and the final round, requesting each round key by index. It presents the ciphertext through a second valid/ready handshake and sits between the host interface and the combinational round/key-schedule modules.

## Interface
- Nk, default 4: key length in 32-bit words (4/6/8).
- Nr, default 10: number of rounds; must equal Nk+6 (elaboration-time check, fatal otherwise).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext offered.
- in_ready  out  1  controller can accept plaintext.
- in_data  in  128  plaintext block.
- round_in  out  128  current state fed to round logic (= state_q).
- round_sel  out  2  00 AddRoundKey, 01 middle round, 10 last round, 11 idle.
- rk_idx  out  4  round-key index requested from key schedule.
- rk_valid  in  1  key for rk_idx available this cycle.
- ark_result  in  128  AddRoundKey(round_in, key[rk_idx]).
- round_result  in  128  full-round output.
- last_result  in  128  last-round output (no MixColumns).
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext (= state_q).
- busy  out  1  block in flight (not IDLE).

## Operation
- States are IDLE, INIT, ROUND, LAST and DONE.
- IDLE: in_ready=1, round_sel=11. When in_valid is high: state_q<=in_data, rk_idx<=0, go to INIT.
- INIT: round_sel=00. When rk_valid is high: state_q<=ark_result, rk_idx<=1, go to ROUND. If Nr==1 the FSM goes to LAST instead (unreachable for legal Nr).
- ROUND: round_sel=01. When rk_valid is high: state_q<=round_result, rk_idx++. Go to LAST when the incremented rk_idx equals Nr.
- LAST: round_sel=10. When rk_valid is high: state_q<=last_result, go to DONE. rk_idx holds at Nr.
- DONE: out_valid=1, round_sel=11. When out_ready is high: go to IDLE, rk_idx<=0.
- rk_valid low in INIT/ROUND/LAST stalls the FSM: no change to state_q, rk_idx or FSM state.
- in_ready is high only in IDLE. There is no accept in the same cycle as DONE→IDLE.
- out_data and state_q are stable throughout DONE, regardless of out_ready.
- rk_idx never exceeds Nr and never wraps.

## Timing
- Reset (asynchronous, any state): FSM→IDLE. state_q=0, rk_idx=0, round_sel=11, out_valid=0, busy=0, in_ready=1 immediately while reset is high.
- Accept edge T. With rk_valid held high: INIT commits at T+1, rounds 1..Nr-1 at T+2..T+Nr, LAST at T+Nr+1. out_valid is high from T+Nr+1 onward, giving a latency of Nr+1 cycles (11 for Nr=10).
- Each low rk_valid cycle adds exactly one cycle of latency.
- Throughput: Nr+3 cycles per block with out_ready held high.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

## Configuration
- AES_CTRL_ABORT_EN defined: adds port abort (in, 1). abort high in INIT/ROUND/LAST/DONE forces IDLE at the next edge and clears state_q and rk_idx to 0. out_valid is never raised for the aborted block, or drops if already in DONE. abort has priority over rk_valid and out_ready and is ignored in IDLE.
- AES_CTRL_ABORT_EN undefined: the port is absent and the logic is not built.

## Structure
- Package aes_pkg holds:
  - the FSM state enum;
  - the round_sel encodings (ROUND_ARK, ROUND_MID, ROUND_LAST, ROUND_IDLE);
  - AES_BLOCK_W=128;
  - a function nr_for_nk(Nk).
- Sub-module aes_round_counter: rk_idx register with clear/increment/terminal-count (rk_idx==Nr-1) outputs. Parameterized by Nr.

## Test plan
- FIPS-197 C.1 with the real round modules: plaintext 00112233445566778899aabbccddeeff, key 000102…0f. Expect out_data=69c4e0d86a7b0430d8cdb78070b4c55a with out_valid at accept+11.
- Key stall: rk_valid low for 3 cycles while rk_idx=5. Expect rk_idx held at 5, state_q unchanged, out_valid at accept+14, same ciphertext.
- Backpressure: out_ready low for 5 cycles in DONE. Expect out_valid and out_data stable, in_ready=0, in_valid ignored. After out_ready: IDLE, in_ready=1 next cycle.
- Reset asserted mid-flight at rk_idx=4. Expect state_q=0, rk_idx=0, busy=0, in_ready=1 immediately. A following block completes correctly at accept+11.
- Nk=8/Nr=14 with FIPS-197 C.3 vector. Expect rk_idx sweeps 0..14, ciphertext 8ea2b7ca516745bfeafc49904b496089 at accept+15.
- With AES_CTRL_ABORT_EN: abort at rk_idx=7 while rk_valid is high. Expect IDLE next edge, no out_valid pulse, and the next block is correct.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller slice.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int RK_IDX_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_LAST,
    ST_DONE
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ROUND_ARK  = 2'b00,
    ROUND_MID  = 2'b01,
    ROUND_LAST = 2'b10,
    ROUND_IDLE = 2'b11
  } round_sel_e;

  // AES ties the round count to the key length: 10/12/14 rounds for 4/6/8 words.
  function automatic int nr_for_nk(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_round_controller_if.sv
// Host handshakes plus the round-logic/key-schedule bus of the AES round controller.
interface aes_round_controller_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] in_data;
  logic [AES_BLOCK_W-1:0] round_in;
  round_sel_e             round_sel;
  logic [RK_IDX_W-1:0]    rk_idx;
  logic                   rk_valid;
  logic [AES_BLOCK_W-1:0] ark_result;
  logic [AES_BLOCK_W-1:0] round_result;
  logic [AES_BLOCK_W-1:0] last_result;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] out_data;
  logic                   busy;

  modport master (
    input  in_valid, in_data, rk_valid, ark_result, round_result, last_result, out_ready,
    output in_ready, round_in, round_sel, rk_idx, out_valid, out_data, busy
  );

  modport slave (
    output in_valid, in_data, rk_valid, ark_result, round_result, last_result, out_ready,
    input  in_ready, round_in, round_sel, rk_idx, out_valid, out_data, busy
  );

endinterface

// File: rtl/aes_round_counter.sv
// Round-key index register: clear, saturating increment at Nr, terminal count at Nr-1.
module aes_round_counter
  import aes_pkg::*;
#(
  parameter int Nr = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                inc,
  output logic [RK_IDX_W-1:0] rk_idx,
  output logic                tc
);

  localparam logic [RK_IDX_W-1:0] MAX_IDX = RK_IDX_W'(Nr);
  localparam logic [RK_IDX_W-1:0] TC_IDX  = RK_IDX_W'(Nr - 1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_idx <= '0;
    end else if (clr) begin
      rk_idx <= '0;
    end else if (inc && (rk_idx != MAX_IDX)) begin
      rk_idx <= rk_idx + 1'b1;
    end
  end

  assign tc = (rk_idx == TC_IDX);

endmodule

// File: rtl/aes_round_controller.sv
// Sequencing FSM for the iterative AES datapath (ARK, rounds 1..Nr-1, last round).
// Define AES_CTRL_ABORT_EN to add the abort input that returns an in-flight block to IDLE.
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic clk,
  input  logic reset,
`ifdef AES_CTRL_ABORT_EN
  input  logic abort,
`endif
  aes_round_controller_if.master bus
);

  if (Nr != nr_for_nk(Nk)) begin : g_bad_nr
    $fatal(1, "aes_round_controller: Nr=%0d must equal Nk+6=%0d", Nr, nr_for_nk(Nk));
  end

  ctrl_state_e            fsm_q, fsm_d;
  logic [AES_BLOCK_W-1:0] state_q, state_d;
  logic                   state_en;
  logic                   cnt_clr, cnt_inc, cnt_tc;
  logic [RK_IDX_W-1:0]    rk_idx;

  aes_round_counter #(.Nr(Nr)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .rk_idx (rk_idx),
    .tc     (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= ST_IDLE;
      // NOTE: the block register is reset because it drives round_in/out_data, which must read 0 after reset.
      state_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (state_en) state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    state_en = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (fsm_q)
      ST_IDLE: if (bus.in_valid) begin
        state_d  = bus.in_data;
        state_en = 1'b1;
        cnt_clr  = 1'b1;
        fsm_d    = ST_INIT;
      end
      ST_INIT: if (bus.rk_valid) begin
        state_d  = bus.ark_result;
        state_en = 1'b1;
        cnt_inc  = 1'b1;
        fsm_d    = cnt_tc ? ST_LAST : ST_ROUND;
      end
      ST_ROUND: if (bus.rk_valid) begin
        state_d  = bus.round_result;
        state_en = 1'b1;
        cnt_inc  = 1'b1;
        if (cnt_tc) fsm_d = ST_LAST;
      end
      ST_LAST: if (bus.rk_valid) begin
        state_d  = bus.last_result;
        state_en = 1'b1;
        fsm_d    = ST_DONE;
      end
      ST_DONE: if (bus.out_ready) begin
        cnt_clr = 1'b1;
        fsm_d   = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
`ifdef AES_CTRL_ABORT_EN
    // Abort outranks key and output handshakes; IDLE has nothing to abort.
    if (abort && (fsm_q != ST_IDLE)) begin
      fsm_d    = ST_IDLE;
      state_d  = '0;
      state_en = 1'b1;
      cnt_clr  = 1'b1;
      cnt_inc  = 1'b0;
    end
`endif
  end

  always_comb begin
    bus.round_sel = ROUND_IDLE;
    case (fsm_q)
      ST_INIT:  bus.round_sel = ROUND_ARK;
      ST_ROUND: bus.round_sel = ROUND_MID;
      ST_LAST:  bus.round_sel = ROUND_LAST;
      default:  bus.round_sel = ROUND_IDLE;
    endcase
  end

  assign bus.in_ready  = (fsm_q == ST_IDLE);
  assign bus.out_valid = (fsm_q == ST_DONE);
  assign bus.busy      = (fsm_q != ST_IDLE);
  assign bus.round_in  = state_q;
  assign bus.out_data  = state_q;
  assign bus.rk_idx    = rk_idx;

endmodule

// File: tb/tb_aes_round_controller.sv
// Directed bench: AES-128 and AES-256 controllers driven by a behavioural round/key-schedule model.
module tb_aes_round_controller;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_round_controller_if b10 ();
  aes_round_controller_if b14 ();

`ifdef AES_CTRL_ABORT_EN
  logic abort10, abort14;
`endif

  aes_round_controller #(.Nk(4), .Nr(10)) dut10 (
    .clk   (clk),
    .reset (reset),
`ifdef AES_CTRL_ABORT_EN
    .abort (abort10),
`endif
    .bus   (b10)
  );

  aes_round_controller #(.Nk(8), .Nr(14)) dut14 (
    .clk   (clk),
    .reset (reset),
`ifdef AES_CTRL_ABORT_EN
    .abort (abort14),
`endif
    .bus   (b14)
  );

  localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] JUNK    = 128'hdeadbeef_cafef00d_01234567_89abcdef;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk10   [15];
  logic [127:0] rk14   [15];
  logic [127:0] s4;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural AES round logic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = sbox_t[s[127-32*((c+r)%4)-8*r -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input bit big);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (big) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else     rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  always_comb begin
    b10.ark_result   = b10.round_in ^ rk10[b10.rk_idx];
    b10.last_result  = sub_shift(b10.round_in) ^ rk10[b10.rk_idx];
    b10.round_result = mix(sub_shift(b10.round_in)) ^ rk10[b10.rk_idx];
  end

  always_comb begin
    b14.ark_result   = b14.round_in ^ rk14[b14.rk_idx];
    b14.last_result  = sub_shift(b14.round_in) ^ rk14[b14.rk_idx];
    b14.round_result = mix(sub_shift(b14.round_in)) ^ rk14[b14.rk_idx];
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sel_exp10(input int k);
    if (k == 0) return 2'b00;
    if (k < 10) return 2'b01;
    if (k == 10) return 2'b10;
    return 2'b11;
  endfunction

  task automatic launch10(input logic [127:0] pt);
    check("in_ready_before_accept", 128'(b10.in_ready), 128'(1));
    b10.in_valid = 1'b1;
    b10.in_data  = pt;
    tick();
    b10.in_valid = 1'b0;
    b10.in_data  = '0;
  endtask

  // Full AES-128 block: round_sel sequence, out_valid exactly at accept+11, ciphertext, release.
  task automatic run10(input logic [127:0] pt, input logic [127:0] ct);
    launch10(pt);
    for (int k = 0; k <= 11; k++) begin
      check("round_sel_seq", 128'(b10.round_sel), 128'(sel_exp10(k)));
      check("out_valid_seq", 128'(b10.out_valid), 128'(k == 11));
      if (k < 11) tick();
    end
    check("cipher128", b10.out_data, ct);
    b10.out_ready = 1'b1;
    tick();
    b10.out_ready = 1'b0;
    check("idle_after_done", 128'(b10.in_ready), 128'(1));
    check("rk_idx_after_done", 128'(b10.rk_idx), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    b10.in_valid = 1'b0; b10.in_data = '0; b10.rk_valid = 1'b1; b10.out_ready = 1'b0;
    b14.in_valid = 1'b0; b14.in_data = '0; b14.rk_valid = 1'b1; b14.out_ready = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    abort10 = 1'b0;
    abort14 = 1'b0;
`endif
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    for (int i = 0; i < 15; i++) begin
      rk10[i] = '0;
      rk14[i] = '0;
    end
    expand_key(KEY128, 4, 1'b0);
    expand_key(KEY256, 8, 1'b1);
    s4 = PT ^ rk10[0];
    for (int r = 1; r <= 4; r++) s4 = mix(sub_shift(s4)) ^ rk10[r];

    // Reset state
    tick();
    tick();
    check("rst_in_ready",  128'(b10.in_ready),  128'(1));
    check("rst_busy",      128'(b10.busy),      128'(0));
    check("rst_out_valid", 128'(b10.out_valid), 128'(0));
    check("rst_round_sel", 128'(b10.round_sel), 128'(2'b11));
    check("rst_round_in",  b10.round_in,        128'(0));
    check("rst_rk_idx",    128'(b10.rk_idx),    128'(0));
    reset = 1'b0;
    tick();

    // FIPS-197 C.1, unstalled
    run10(PT, CT128);

    // Key stall of 3 cycles at rk_idx=5
    launch10(PT);
    for (int k = 0; k < 5; k++) tick();
    check("stall_pre_idx",   128'(b10.rk_idx), 128'(5));
    check("stall_pre_state", b10.round_in,     s4);
    b10.rk_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_idx",   128'(b10.rk_idx),    128'(5));
      check("stall_state", b10.round_in,        s4);
      check("stall_sel",   128'(b10.round_sel), 128'(2'b01));
    end
    b10.rk_valid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("stall_valid_at_13", 128'(b10.out_valid), 128'(0));
    tick();
    check("stall_valid_at_14", 128'(b10.out_valid), 128'(1));
    check("stall_cipher",      b10.out_data,        CT128);

    // Backpressure in DONE with a competing in_valid
    b10.in_valid = 1'b1;
    b10.in_data  = JUNK;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_out_valid", 128'(b10.out_valid), 128'(1));
      check("bp_out_data",  b10.out_data,        CT128);
      check("bp_in_ready",  128'(b10.in_ready),  128'(0));
    end
    b10.out_ready = 1'b1;
    tick();
    b10.in_valid  = 1'b0;
    b10.in_data   = '0;
    b10.out_ready = 1'b0;
    check("bp_release_ready", 128'(b10.in_ready),  128'(1));
    check("bp_release_valid", 128'(b10.out_valid), 128'(0));
    check("bp_no_accept",     b10.round_in,        CT128);
    tick();
    check("bp_still_idle", 128'(b10.busy), 128'(0));

    // Asynchronous reset mid-flight at rk_idx=4
    launch10(PT);
    for (int k = 0; k < 4; k++) tick();
    check("mid_rst_pre_idx", 128'(b10.rk_idx), 128'(4));
    reset = 1'b1;
    #1;
    check("mid_rst_state",    b10.round_in,       128'(0));
    check("mid_rst_idx",      128'(b10.rk_idx),   128'(0));
    check("mid_rst_busy",     128'(b10.busy),     128'(0));
    check("mid_rst_in_ready", 128'(b10.in_ready), 128'(1));
    #1;
    reset = 1'b0;
    tick();
    run10(PT, CT128);

    // AES-256 (Nr=14), FIPS-197 C.3
    check("n14_in_ready", 128'(b14.in_ready), 128'(1));
    b14.in_valid = 1'b1;
    b14.in_data  = PT;
    tick();
    b14.in_valid = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      check("n14_rk_idx",    128'(b14.rk_idx),    128'(k));
      check("n14_out_valid", 128'(b14.out_valid), 128'(0));
      tick();
    end
    check("n14_valid_at_15", 128'(b14.out_valid), 128'(1));
    check("n14_cipher",      b14.out_data,        CT256);
    b14.out_ready = 1'b1;
    tick();
    b14.out_ready = 1'b0;
    check("n14_idle", 128'(b14.in_ready), 128'(1));

`ifdef AES_CTRL_ABORT_EN
    // Abort at rk_idx=7 with rk_valid high
    launch10(PT);
    for (int k = 0; k < 7; k++) tick();
    check("abort_pre_idx", 128'(b10.rk_idx), 128'(7));
    abort10 = 1'b1;
    tick();
    abort10 = 1'b0;
    check("abort_busy",     128'(b10.busy),     128'(0));
    check("abort_in_ready", 128'(b10.in_ready), 128'(1));
    check("abort_idx",      128'(b10.rk_idx),   128'(0));
    check("abort_state",    b10.round_in,       128'(0));
    for (int k = 0; k < 6; k++) begin
      check("abort_no_valid", 128'(b10.out_valid), 128'(0));
      tick();
    end
    run10(PT, CT128);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
